serial_add_arbiter: RTL



---
 rtl/serial_add_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_arbiter
//  Purpose  : Round-robin arbiter in front of one bit-serial full adder.
//             The winner's operands are captured, added LSB-first over
//             WIDTH cycles, and the parallel sum is returned with a
//             one-cycle done strobe tagged with the requester index.
//  Ports    : clk, reset (async, active-high)
//             req[NREQ], a_in/b_in[NREQ*WIDTH] (requester i at i*WIDTH),
//             cin_in[NREQ]
//             gnt[NREQ] one-hot, busy, result[WIDTH], cout, done,
//             done_id[IDW], ovf (only with SERIAL_ADD_ARB_OVF_EN)
//  Options  : define SERIAL_ADD_ARB_OVF_EN to add the signed-overflow output
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  a_in,
    input  logic [NREQ*WIDTH-1:0]  b_in,
    input  logic [NREQ-1:0]        cin_in,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic [WIDTH-1:0]       result,
    output logic                   cout,
    output logic                   done,
    output logic [IDW-1:0]         done_id
`ifdef SERIAL_ADD_ARB_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [WIDTH-1:0]  shift_a_q, shift_a_d;
    logic [WIDTH-1:0]  shift_b_q, shift_b_d;
    logic [WIDTH-1:0]  sum_q,     sum_d;
    logic              carry_q,   carry_d;
    logic [CNTW-1:0]   cnt_q,     cnt_d;
    logic [NREQ-1:0]   gnt_q,     gnt_d;
    logic [IDW-1:0]    winner_q,  winner_d;
    logic [IDW-1:0]    rr_q,      rr_d;
    logic [WIDTH-1:0]  result_q,  result_d;
    logic              cout_q,    cout_d;
    logic [IDW-1:0]    done_id_q, done_id_d;
`ifdef SERIAL_ADD_ARB_OVF_EN
    logic              ovf_q,     ovf_d;
`endif

    // Round-robin search: first set request at or above rr_q, wrapping.
    logic              arb_found;
    logic [IDW-1:0]    arb_win;
    logic [NREQ-1:0]   arb_onehot;
    int                arb_idx;

    always_comb begin
        arb_found  = 1'b0;
        arb_win    = '0;
        arb_onehot = '0;
        arb_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = int'(rr_q) + i;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!arb_found && (|(req & (NREQ'(1) << arb_idx)))) begin
                arb_found  = 1'b1;
                arb_win    = IDW'(arb_idx);
                arb_onehot = NREQ'(1) << arb_idx;
            end
        end
    end

    // One bit of the serial add: {carry, s} = a0 + b0 + carry.
    logic [1:0] bit_sum;
    assign bit_sum = {1'b0, shift_a_q[0]} + {1'b0, shift_b_q[0]} + {1'b0, carry_q};

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        winner_d  = winner_q;
        rr_d      = rr_q;
        result_d  = result_q;
        cout_d    = cout_q;
        done_id_d = done_id_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    shift_a_d = WIDTH'(a_in >> (int'(arb_win) * WIDTH));
                    shift_b_d = WIDTH'(b_in >> (int'(arb_win) * WIDTH));
                    carry_d   = |(cin_in & arb_onehot);
                    sum_d     = '0;
                    cnt_d     = '0;
                    gnt_d     = arb_onehot;
                    winner_d  = arb_win;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                carry_d   = bit_sum[1];
                sum_d     = {bit_sum[0], sum_q[WIDTH-1:1]};
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                cnt_d     = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    // Last bit: publish the completed sum as DONE is entered,
                    // so the outputs are stable for the whole done cycle.
                    result_d  = {bit_sum[0], sum_q[WIDTH-1:1]};
                    cout_d    = bit_sum[1];
                    done_id_d = winner_q;
                    rr_d      = (int'(winner_q) == NREQ - 1) ? '0 : winner_q + IDW'(1);
`ifdef SERIAL_ADD_ARB_OVF_EN
                    // carry_q here is the carry into the MSB position.
                    ovf_d     = carry_q ^ bit_sum[1];
`endif
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            winner_q  <= '0;
            rr_q      <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            done_id_q <= '0;
`ifdef SERIAL_ADD_ARB_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            winner_q  <= winner_d;
            rr_q      <= rr_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            done_id_q <= done_id_d;
`ifdef SERIAL_ADD_ARB_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign cout    = cout_q;
    assign done_id = done_id_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule
`default_nettype wire
